// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer and the scoring counter.
package game_pkg;

  // Game phase encoding; the scoring counter decodes the same values.
  typedef enum logic [1:0] {
    ST_SELECT    = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_INGAME    = 2'd2,
    ST_FINISH    = 2'd3
  } state_e;

  localparam int unsigned KEY_W   = 9;
  localparam int unsigned VALUE_W = 7;
  localparam int unsigned CD_W    = 2;
  localparam int unsigned SUB_W   = 7;
  localparam int unsigned SUB_MAX = 99;

  // Make codes; bit 8 (extended prefix) must be clear.
  localparam logic [KEY_W-1:0] KEY_ENTER = 9'h05A;
  localparam logic [KEY_W-1:0] KEY_ESC   = 9'h076;
  localparam logic [KEY_W-1:0] KEY_TAB   = 9'h00D;
  localparam logic [KEY_W-1:0] KEY_PLUS  = 9'h055;
  localparam logic [KEY_W-1:0] KEY_MINUS = 9'h04E;

  // Mode 0: timed, value in seconds.
  localparam logic [VALUE_W-1:0] M0_DEF  = 7'd15;
  localparam logic [VALUE_W-1:0] M0_MIN  = 7'd15;
  localparam logic [VALUE_W-1:0] M0_MAX  = 7'd60;
  localparam logic [VALUE_W-1:0] M0_STEP = 7'd15;
  // Mode 1: word count.
  localparam logic [VALUE_W-1:0] M1_DEF  = 7'd25;
  localparam logic [VALUE_W-1:0] M1_MIN  = 7'd10;
  localparam logic [VALUE_W-1:0] M1_MAX  = 7'd60;
  localparam logic [VALUE_W-1:0] M1_STEP = 7'd5;

  // Default target when a mode is entered.
  function automatic logic [VALUE_W-1:0] mode_default(input logic m);
    return m ? M1_DEF : M0_DEF;
  endfunction

  // One saturating step of the target up or down within the mode's range.
  function automatic logic [VALUE_W-1:0] step_value(input logic m,
                                                    input logic [VALUE_W-1:0] v,
                                                    input logic up);
    logic [VALUE_W-1:0] lo;
    logic [VALUE_W-1:0] hi;
    logic [VALUE_W-1:0] st;
    logic [VALUE_W-1:0] res;
    lo = m ? M1_MIN  : M0_MIN;
    hi = m ? M1_MAX  : M0_MAX;
    st = m ? M1_STEP : M0_STEP;
    if (up) res = (v >= hi - st) ? hi : v + st;
    else    res = (v <= lo + st) ? lo : v - st;
    return res;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_gen #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wrap_c;

  // Wrap detection and next count.
  always_comb begin
    wrap_c = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d  = wrap_c ? '0 : cnt_q + CNT_W'(1);
  end

  // Divider register; tick is registered off the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= wrap_c;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: setup screen, countdown, in-game and result phases.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 1000000,
  parameter int unsigned COUNT_SEC   = 3,
  parameter int unsigned FINISH_HOLD = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [127:0]       key_down,
  input  logic [KEY_W-1:0]   last_change,
  input  logic               key_valid,
  input  logic               finish,
  output logic [1:0]         state,
  output logic               mode,
  output logic [VALUE_W-1:0] value,
  output logic [CD_W-1:0]    cd_sec,
  output logic               tick
);

  localparam int unsigned HOLD_W = $clog2(FINISH_HOLD + 1);

  state_e             state_q,  state_d;
  logic               mode_q,   mode_d;
  logic [VALUE_W-1:0] value_q,  value_d;
  logic [CD_W-1:0]    cd_q,     cd_d;
  logic [SUB_W-1:0]   sub_q,    sub_d;
  logic [HOLD_W-1:0]  hold_q,   hold_d;
  logic               prev_q;
  logic               press_q,  press_d;
  logic [KEY_W-1:0]   code_q;
  logic [127:0]       others_c;
  logic [6:0]         idx_c;
  logic               enter_c, esc_c, tab_c, plus_c, minus_c;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Press event: fresh make of a key that is the only one held.
  always_comb begin
    idx_c           = last_change[6:0];
    others_c        = key_down;
    others_c[idx_c] = 1'b0;
    press_d         = key_valid && key_down[idx_c] && !prev_q && (others_c == '0);
  end

  // Edge tracker and registered press with its code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      code_q  <= '0;
    end else begin
      prev_q  <= key_down[idx_c];
      press_q <= press_d;
      code_q  <= last_change;
    end
  end

  // Key decode of the registered press.
  always_comb begin
    enter_c = press_q && (code_q == KEY_ENTER);
    esc_c   = press_q && (code_q == KEY_ESC);
    tab_c   = press_q && (code_q == KEY_TAB);
    plus_c  = press_q && (code_q == KEY_PLUS);
    minus_c = press_q && (code_q == KEY_MINUS);
  end

  // Next-state logic for phase, selection and the phase timers.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    value_d = value_q;
    cd_d    = cd_q;
    sub_d   = sub_q;
    hold_d  = hold_q;
    case (state_q)
      ST_SELECT: begin
        if (enter_c) begin
          state_d = ST_COUNTDOWN;
          cd_d    = CD_W'(COUNT_SEC);
          sub_d   = '0;
        end else if (tab_c) begin
          mode_d  = !mode_q;
          value_d = mode_default(!mode_q);
        end else if (plus_c) begin
          value_d = step_value(mode_q, value_q, 1'b1);
        end else if (minus_c) begin
          value_d = step_value(mode_q, value_q, 1'b0);
        end
      end
      ST_COUNTDOWN: begin
        if (esc_c) begin
          state_d = ST_SELECT;
          cd_d    = '0;
        end else if (tick) begin
          if (sub_q == SUB_W'(SUB_MAX)) begin
            sub_d = '0;
            if (cd_q == CD_W'(1)) begin
              state_d = ST_INGAME;
              cd_d    = '0;
            end else begin
              cd_d = cd_q - CD_W'(1);
            end
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
      end
      ST_INGAME: begin
        // finish takes priority over a coincident ESC
        if (finish) begin
          state_d = ST_FINISH;
          hold_d  = '0;
        end else if (esc_c) begin
          state_d = ST_SELECT;
        end
      end
      ST_FINISH: begin
        if (esc_c) begin
          state_d = ST_SELECT;
        end else if (enter_c && (hold_q == HOLD_W'(FINISH_HOLD))) begin
          state_d = ST_SELECT;
        end else if (tick && (hold_q != HOLD_W'(FINISH_HOLD))) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_SELECT;
    endcase
  end

  // Phase and selection registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SELECT;
      mode_q  <= 1'b0;
      value_q <= M0_DEF;
      cd_q    <= '0;
      sub_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      value_q <= value_d;
      cd_q    <= cd_d;
      sub_q   <= sub_d;
      hold_q  <= hold_d;
    end
  end

  assign state  = state_q;
  assign mode   = mode_q;
  assign value  = value_q;
  assign cd_sec = cd_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a shortened tick divider.
module tb_game_ctrl;

  localparam int unsigned TDIV = 10;

  localparam logic [8:0] K_ENTER = 9'h05A;
  localparam logic [8:0] K_ESC   = 9'h076;
  localparam logic [8:0] K_TAB   = 9'h00D;
  localparam logic [8:0] K_PLUS  = 9'h055;
  localparam logic [8:0] K_MINUS = 9'h04E;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         finish;
  logic [1:0]   state;
  logic         mode;
  logic [6:0]   value;
  logic [1:0]   cd_sec;
  logic         tick;

  int total = 0;
  int bad   = 0;

  game_ctrl #(.TICK_DIV(TDIV), .COUNT_SEC(3), .FINISH_HOLD(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .finish      (finish),
    .state       (state),
    .mode        (mode),
    .value       (value),
    .cd_sec      (cd_sec),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One key_valid strobe with the given code; returns one negedge later.
  task automatic send(input logic [8:0] code, input logic down);
    @(negedge clk);
    last_change          = code;
    key_down[code[6:0]]  = down;
    key_valid            = 1'b1;
    @(negedge clk);
    key_valid            = 1'b0;
  endtask

  // Tap a key; returns at the first negedge where its effect is visible.
  task automatic press_key(input logic [8:0] code);
    send(code, 1'b1);
    key_down[code[6:0]] = 1'b0;
    @(negedge clk);
  endtask

  // Count tick pulses from the current negedge on, with a cycle bound.
  task automatic wait_ticks(input int n);
    int seen  = 0;
    int guard = 0;
    while (seen < n && guard < n * TDIV + 50) begin
      if (tick === 1'b1) seen++;
      if (seen < n) begin
        @(negedge clk);
        guard++;
      end
    end
    chk("tick_wait", 32'(seen), 32'(n));
  endtask

  initial begin
    int exp_v;
    int gap;
    rst         = 1'b1;
    key_down    = '0;
    last_change = '0;
    key_valid   = 1'b0;
    finish      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_value", 32'(value), 15);
    chk("rst_cd", 32'(cd_sec), 0);
    chk("rst_tick", 32'(tick), 0);
    rst = 1'b0;

    // tick period
    gap = 0;
    while (tick !== 1'b1 && gap < 4 * TDIV) begin @(negedge clk); gap++; end
    gap = 0;
    do begin @(negedge clk); gap++; end while (tick !== 1'b1 && gap < 4 * TDIV);
    chk("tick_period", 32'(gap), 32'(TDIV));

    // mode 0 stepping
    exp_v = 15;
    for (int i = 0; i < 5; i++) begin
      press_key(K_PLUS);
      exp_v = (exp_v + 15 > 60) ? 60 : exp_v + 15;
      chk("m0_plus", 32'(value), 32'(exp_v));
    end
    for (int i = 0; i < 5; i++) begin
      press_key(K_MINUS);
      exp_v = (exp_v - 15 < 15) ? 15 : exp_v - 15;
      chk("m0_minus", 32'(value), 32'(exp_v));
    end

    // mode 1 stepping
    press_key(K_TAB);
    chk("tab_mode1", 32'(mode), 1);
    chk("tab_val1", 32'(value), 25);
    exp_v = 25;
    for (int i = 0; i < 8; i++) begin
      press_key(K_PLUS);
      exp_v = (exp_v + 5 > 60) ? 60 : exp_v + 5;
      chk("m1_plus", 32'(value), 32'(exp_v));
    end
    for (int i = 0; i < 11; i++) begin
      press_key(K_MINUS);
      exp_v = (exp_v - 5 < 10) ? 10 : exp_v - 5;
    end
    chk("m1_floor", 32'(value), 10);
    press_key(K_TAB);
    chk("tab_mode0", 32'(mode), 0);
    chk("tab_val0", 32'(value), 15);
    press_key(K_PLUS);
    chk("sel_30", 32'(value), 30);

    // full countdown
    send(K_ENTER, 1'b1);
    chk("enter_1cyc", 32'(state), 0);
    key_down[K_ENTER[6:0]] = 1'b0;
    @(negedge clk);
    chk("enter_state", 32'(state), 1);
    chk("enter_cd", 32'(cd_sec), 3);
    wait_ticks(100);
    chk("cd3_edge", 32'(cd_sec), 3);
    @(negedge clk);
    chk("cd2", 32'(cd_sec), 2);
    wait_ticks(100);
    @(negedge clk);
    chk("cd1", 32'(cd_sec), 1);
    wait_ticks(100);
    chk("cd_last_edge", 32'(state), 1);
    @(negedge clk);
    chk("ingame_state", 32'(state), 2);
    chk("ingame_cd", 32'(cd_sec), 0);

    press_key(K_ESC);
    chk("ingame_esc", 32'(state), 0);

    // abort countdown; selection frozen meanwhile
    press_key(K_ENTER);
    chk("cd_again", 32'(state), 1);
    press_key(K_PLUS);
    press_key(K_TAB);
    chk("frozen_val", 32'(value), 30);
    chk("frozen_mode", 32'(mode), 0);
    wait_ticks(140);
    chk("cd_mid", 32'(cd_sec), 2);
    press_key(K_ESC);
    chk("abort_state", 32'(state), 0);
    chk("abort_cd", 32'(cd_sec), 0);

    // into INGAME again, finish coinciding with ESC
    press_key(K_ENTER);
    wait_ticks(300);
    @(negedge clk);
    chk("ingame2", 32'(state), 2);
    send(K_ESC, 1'b1);
    finish = 1'b1;
    key_down[K_ESC[6:0]] = 1'b0;
    @(negedge clk);
    chk("finish_wins", 32'(state), 3);
    finish = 1'b0;
    wait_ticks(50);
    press_key(K_ENTER);
    chk("hold_early", 32'(state), 3);
    wait_ticks(60);
    press_key(K_ENTER);
    chk("hold_done", 32'(state), 0);
    chk("keep_mode", 32'(mode), 0);
    chk("keep_val", 32'(value), 30);

    // auto-repeat yields one event
    key_down[K_TAB[6:0]] = 1'b1;
    for (int i = 0; i < 3; i++) send(K_TAB, 1'b1);
    key_down[K_TAB[6:0]] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rep_tab_mode", 32'(mode), 1);
    chk("rep_tab_val", 32'(value), 25);
    key_down[K_ENTER[6:0]] = 1'b1;
    for (int i = 0; i < 3; i++) send(K_ENTER, 1'b1);
    key_down[K_ENTER[6:0]] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rep_enter", 32'(state), 1);
    chk("rep_enter_cd", 32'(cd_sec), 3);
    press_key(K_ESC);
    chk("rep_esc", 32'(state), 0);

    // second key held blocks the press
    key_down[7'h1C] = 1'b1;
    press_key(K_ENTER);
    key_down[7'h1C] = 1'b0;
    @(negedge clk);
    chk("ghost_enter", 32'(state), 0);

    // break code gives no event
    send(K_PLUS, 1'b0);
    repeat (2) @(negedge clk);
    chk("break_plus", 32'(value), 25);

    // asynchronous reset mid countdown
    press_key(K_ENTER);
    chk("pre_rst", 32'(state), 1);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_mode", 32'(mode), 0);
    chk("arst_value", 32'(value), 15);
    chk("arst_cd", 32'(cd_sec), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
